// File: rtl/key_matrix_scanner.sv
// Key matrix scanner: drives six rows in turn, debounces 36 keys once per frame
// and queues press/release events in a small FIFO for a downstream consumer.
module key_matrix_scanner #(
  parameter int SETTLE_CYCLES   = 64,
  parameter int DEBOUNCE_FRAMES = 4,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [5:0]  col_n,
  output logic [5:0]  row_n,
  output logic [35:0] keys,
  output logic        evt_valid,
  input  logic        evt_ready,
  output logic [5:0]  evt_key,
  output logic        evt_pressed,
  output logic        frame_done,
  output logic        overflow
);

  // state   | meaning
  // SETTLE  | row driven, waiting for the columns to settle
  // SAMPLE  | capture synchronized columns of the driven row
  // EVAL    | debounce one column (one key) per cycle
  // ADVANCE | all rows released, step to the next row
  typedef enum logic [1:0] {
    ST_SETTLE,
    ST_SAMPLE,
    ST_EVAL,
    ST_ADVANCE
  } state_t;

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FIFO_FULL   = CW'(FIFO_DEPTH);
  localparam logic [15:0]   SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
  localparam logic [3:0]    DEB_LAST    = 4'(DEBOUNCE_FRAMES - 1);

  state_t           state_q, state_d;
  logic [2:0]       row_q, row_d;
  logic [2:0]       col_q, col_d;
  logic [15:0]      settle_q, settle_d;
  logic             active_q;
  logic [5:0]       sync1_q, sync2_q;
  logic [5:0]       raw_q, raw_d;
  logic [35:0]      keys_q, keys_d;
  logic [35:0][3:0] cnt_q, cnt_d;
  logic [5:0]       key_idx;
  logic             push;
  logic [6:0]       push_data;

  logic [FIFO_DEPTH-1:0][6:0] mem_q;
  logic [PW-1:0]              wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]              count_q;
  logic                       overflow_q;
  logic                       pop, accept;

  assign key_idx = {3'b000, row_q} * 6'd6 + {3'b000, col_q};

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    settle_d  = settle_q;
    raw_d     = raw_q;
    keys_d    = keys_q;
    cnt_d     = cnt_q;
    push      = 1'b0;
    push_data = 7'd0;
    if (!enable) begin
      state_d  = ST_SETTLE;
      row_d    = 3'd0;
      col_d    = 3'd0;
      settle_d = 16'd0;
    end else if (active_q) begin
      case (state_q)
        ST_SETTLE: begin
          if (settle_q == SETTLE_LAST) begin
            settle_d = 16'd0;
            state_d  = ST_SAMPLE;
          end else begin
            settle_d = settle_q + 16'd1;
          end
        end
        ST_SAMPLE: begin
          raw_d   = ~sync2_q;
          col_d   = 3'd0;
          state_d = ST_EVAL;
        end
        ST_EVAL: begin
          if (raw_q[col_q] == keys_q[key_idx]) begin
            cnt_d[key_idx] = 4'd0;
          end else if (cnt_q[key_idx] == DEB_LAST) begin
            keys_d[key_idx] = ~keys_q[key_idx];
            cnt_d[key_idx]  = 4'd0;
            push            = 1'b1;
            push_data       = {key_idx, ~keys_q[key_idx]};
          end else begin
            cnt_d[key_idx] = cnt_q[key_idx] + 4'd1;
          end
          if (col_q == 3'd5) begin
            col_d   = 3'd0;
            state_d = ST_ADVANCE;
          end else begin
            col_d = col_q + 3'd1;
          end
        end
        ST_ADVANCE: begin
          row_d   = (row_q == 3'd5) ? 3'd0 : row_q + 3'd1;
          state_d = ST_SETTLE;
        end
        default: state_d = ST_SETTLE;
      endcase
    end
  end

  // active_q delays the start of scanning by one clock so a rising enable
  // always begins with a complete SETTLE on row 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_SETTLE;
      row_q    <= 3'd0;
      col_q    <= 3'd0;
      settle_q <= 16'd0;
      active_q <= 1'b0;
      sync1_q  <= 6'h3F;
      sync2_q  <= 6'h3F;
      raw_q    <= 6'd0;
      keys_q   <= 36'd0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      col_q    <= col_d;
      settle_q <= settle_d;
      active_q <= enable;
      sync1_q  <= col_n;
      sync2_q  <= sync1_q;
      raw_q    <= raw_d;
      keys_q   <= keys_d;
      cnt_q    <= cnt_d;
    end
  end

  assign pop    = evt_valid && evt_ready;
  assign accept = push && ((count_q != FIFO_FULL) || pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (accept) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      case ({accept, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (push && !accept) begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign row_n       = (active_q && state_q != ST_ADVANCE) ? ~(6'b000001 << row_q) : 6'h3F;
  assign keys        = keys_q;
  assign evt_valid   = (count_q != '0);
  assign evt_key     = evt_valid ? mem_q[rd_ptr_q][6:1] : 6'd0;
  assign evt_pressed = evt_valid ? mem_q[rd_ptr_q][0] : 1'b0;
  assign frame_done  = (state_q == ST_ADVANCE) && (row_q == 3'd5);
  assign overflow    = overflow_q;

endmodule
